// File: rtl/if_stage.sv
// if_stage: RV32I instruction-fetch stage and IF/ID pipeline register.
// Keeps the fetch PC and runs a req/gnt/rvalid handshake with instruction memory,
// allowing at most one request in flight. A one-entry hold buffer catches a
// response that lands while decode is stalled. Flushes squash decode and drop
// the in-flight response.
// Optional performance counters are compiled in when IF_PERF_CNT_EN is defined.
module if_stage #(
    localparam int unsigned XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_target_E,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_D,
    output logic [XLEN-1:0] pc_D,
    output logic [XLEN-1:0] pc_plus4_D,
    output logic            valid_D,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_bubbles
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // DROP: a request is in flight whose response must be discarded
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    fetch_state_t    state;
    logic [XLEN-1:0] pc_F;
    logic [XLEN-1:0] pend_pc;
    logic            hold_valid;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc;

    logic            grant;
    logic            rsp_live;
    logic            load_hold;
    logic            load_rsp;
    logic            load_bubble;

    // Request only when nothing useful is in flight and decode can make progress
    assign imem_req  = !flush && !stall && !hold_valid &&
                       ((state == S_IDLE) || ((state == S_WAIT) && imem_rvalid));
    assign imem_addr = pc_F;
    assign grant     = imem_req && imem_gnt;

    // A response is usable only in WAIT and only when no flush squashes it
    assign rsp_live  = (state == S_WAIT) && imem_rvalid && !flush;

    // Decode-slot source select: hold buffer first, then live response, else bubble
    assign load_hold   = !flush && !stall && hold_valid;
    assign load_rsp    = !flush && !stall && !hold_valid && rsp_live;
    assign load_bubble = flush || (!stall && !hold_valid && !rsp_live);

    // Fetch handshake state machine
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (flush) begin
            case (state)
                S_WAIT:  state <= imem_rvalid ? S_IDLE : S_DROP;
                S_DROP:  state <= imem_rvalid ? S_IDLE : S_DROP;
                default: state <= S_IDLE;
            endcase
        end else if (grant) begin
            state <= S_WAIT;
        end else begin
            case (state)
                S_WAIT:  if (imem_rvalid) state <= S_IDLE;
                S_DROP:  if (imem_rvalid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Fetch PC and the PC of the outstanding request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_F    <= RESET_PC;
            pend_pc <= RESET_PC;
        end else if (flush) begin
            pc_F    <= pc_target_E;
        end else if (grant) begin
            pend_pc <= pc_F;
            pc_F    <= pc_F + PC_STEP;
        end
    end

    // Hold buffer: parks a response that arrives while decode is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_instr <= NOP;
            hold_pc    <= RESET_PC;
        end else if (flush || !stall) begin
            hold_valid <= 1'b0;
        end else if (rsp_live) begin
            hold_valid <= 1'b1;
            hold_instr <= imem_rdata;
            hold_pc    <= pend_pc;
        end
    end

    // IF/ID pipeline register; a bubble keeps pc_D so the PC pair stays consistent
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_D    <= 1'b0;
            instr_D    <= NOP;
            pc_D       <= '0;
            pc_plus4_D <= PC_STEP;
        end else if (load_bubble) begin
            valid_D    <= 1'b0;
            instr_D    <= NOP;
        end else if (load_hold) begin
            valid_D    <= 1'b1;
            instr_D    <= hold_instr;
            pc_D       <= hold_pc;
            pc_plus4_D <= hold_pc + PC_STEP;
        end else if (load_rsp) begin
            valid_D    <= 1'b1;
            instr_D    <= imem_rdata;
            pc_D       <= pend_pc;
            pc_plus4_D <= pend_pc + PC_STEP;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Performance counters: real instructions and bubbles entering decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (load_hold || load_rsp) perf_fetched <= perf_fetched + XLEN'(1);
            if (load_bubble)           perf_bubbles <= perf_bubbles + XLEN'(1);
        end
    end
`else
    assign perf_fetched = '0;
    assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a one-outstanding memory model
// whose response latency is programmable and whose data equals the address.
module tb_if_stage;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] pc_target_E;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc_plus4_D;
    logic        valid_D;
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;

    int checks   = 0;
    int failures = 0;

    // memory model state
    logic        gnt_en   = 1'b0;
    int          lat      = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_slot = 32'h0;

    if_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .pc_target_E (pc_target_E),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .pc_plus4_D  (pc_plus4_D),
        .valid_D     (valid_D),
        .perf_fetched(perf_fetched),
        .perf_bubbles(perf_bubbles)
    );

    always #5 clk = ~clk;

    assign imem_gnt    = gnt_en;
    assign imem_rvalid = mem_busy && (mem_cnt == 0);
    assign imem_rdata  = imem_rvalid ? mem_slot : 32'hDEAD_BEEF;

    // memory: response arrives lat cycles after grant, independent of DUT reset
    always @(posedge clk) begin
        if (imem_req && imem_gnt) begin
            mem_busy <= 1'b1;
            mem_slot <= imem_addr;
            mem_cnt  <= lat - 1;
        end else if (mem_busy) begin
            if (mem_cnt == 0) mem_busy <= 1'b0;
            else              mem_cnt  <= mem_cnt - 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; pc_target_E = 32'h0;
        gnt_en = 1'b0; lat = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (valid_D !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", valid_D); end
        checks++; if (instr_D !== NOP_W) begin failures++; $display("FAIL rst_instr: got %h expected %h", instr_D, NOP_W); end
        checks++; if (pc_D !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h expected 0", pc_D); end
        checks++; if (pc_plus4_D !== 32'h4) begin failures++; $display("FAIL rst_pc4: got %h expected 4", pc_plus4_D); end
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL rst_req: got %b/%h expected 1/0", imem_req, imem_addr); end
        checks++; if (perf_fetched !== 32'h0 || perf_bubbles !== 32'h0) begin failures++; $display("FAIL rst_perf: got %h/%h expected 0/0", perf_fetched, perf_bubbles); end
        @(negedge clk);
    endtask

    // cycles 0..4: zero-wait stream
    task automatic test_stream;
        rst_n = 1'b1; gnt_en = 1'b1;
        for (int t = 0; t <= 4; t++) begin
            #1;
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * t)) begin failures++; $display("FAIL stream_req[%0d]: got %b/%h expected 1/%h", t, imem_req, imem_addr, 32'(4 * t)); end
            if (t >= 2) begin
                checks++; if (valid_D !== 1'b1 || pc_D !== 32'(4 * (t - 2)) || instr_D !== 32'(4 * (t - 2)) || pc_plus4_D !== 32'(4 * (t - 1))) begin
                    failures++; $display("FAIL stream_D[%0d]: got %b %h %h %h expected 1 %h", t, valid_D, pc_D, instr_D, pc_plus4_D, 32'(4 * (t - 2)));
                end
            end else begin
                checks++; if (valid_D !== 1'b0 || instr_D !== NOP_W || pc_D !== 32'h0) begin
                    failures++; $display("FAIL stream_bubble[%0d]: got %b %h %h expected 0 NOP 0", t, valid_D, instr_D, pc_D);
                end
            end
            @(negedge clk);
        end
    endtask

    // cycles 5..12: stall while 0x10 is returning
    task automatic test_stall;
        for (int t = 5; t <= 7; t++) begin
            stall = 1'b1; #1;
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req[%0d]: got %b expected 0", t, imem_req); end
            checks++; if (valid_D !== 1'b1 || pc_D !== 32'hC || instr_D !== 32'hC) begin failures++; $display("FAIL stall_hold_D[%0d]: got %b %h %h expected 1 c c", t, valid_D, pc_D, instr_D); end
            @(negedge clk);
        end
        stall = 1'b0; #1;
        checks++; if (imem_req !== 1'b0 || pc_D !== 32'hC) begin failures++; $display("FAIL stall_release: got %b %h expected 0 c", imem_req, pc_D); end
        @(negedge clk); #1;
        checks++; if (valid_D !== 1'b1 || pc_D !== 32'h10 || instr_D !== 32'h10 || pc_plus4_D !== 32'h14) begin failures++; $display("FAIL stall_hold_out: got %b %h %h %h expected 1 10 10 14", valid_D, pc_D, instr_D, pc_plus4_D); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin failures++; $display("FAIL stall_resume: got %b %h expected 1 14", imem_req, imem_addr); end
        @(negedge clk); #1;
        checks++; if (valid_D !== 1'b0 || instr_D !== NOP_W || pc_D !== 32'h10) begin failures++; $display("FAIL stall_gap: got %b %h %h expected 0 NOP 10", valid_D, instr_D, pc_D); end
        @(negedge clk); #1;
        checks++; if (valid_D !== 1'b1 || pc_D !== 32'h14) begin failures++; $display("FAIL stall_next: got %b %h expected 1 14", valid_D, pc_D); end
        @(negedge clk);
        lat = 3; #1;
        checks++; if (valid_D !== 1'b1 || pc_D !== 32'h18) begin failures++; $display("FAIL stall_next2: got %b %h expected 1 18", valid_D, pc_D); end
        @(negedge clk);
    endtask

    // cycles 13..21: flush while 0x20 is outstanding with 3-cycle latency
    task automatic test_flush;
        int nvalid = 0;
        int n100   = 0;
        flush = 1'b1; pc_target_E = 32'h100; #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL flush_req: got %b expected 0", imem_req); end
        checks++; if (valid_D !== 1'b1 || pc_D !== 32'h1C) begin failures++; $display("FAIL flush_preD: got %b %h expected 1 1c", valid_D, pc_D); end
        @(negedge clk);
        for (int t = 14; t <= 21; t++) begin
            flush = 1'b0;
            if (t == 19) gnt_en = 1'b0;
            #1;
            if (valid_D === 1'b1) begin
                nvalid++;
                if (pc_D === 32'h100 && instr_D === 32'h100) n100++;
            end
            if (t == 14) begin
                checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100 || valid_D !== 1'b0 || pc_D !== 32'h1C) begin
                    failures++; $display("FAIL flush_drop: got %b %h %b %h expected 0 100 0 1c", imem_req, imem_addr, valid_D, pc_D);
                end
            end
            if (t == 15) begin
                checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL flush_stale_req: got %b expected 0", imem_req); end
            end
            if (t == 16) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL flush_target_req: got %b %h expected 1 100", imem_req, imem_addr); end
            end
            if (t == 20) begin
                checks++; if (valid_D !== 1'b1 || pc_D !== 32'h100 || pc_plus4_D !== 32'h104) begin failures++; $display("FAIL flush_target_D: got %b %h %h expected 1 100 104", valid_D, pc_D, pc_plus4_D); end
            end
            @(negedge clk);
        end
        checks++; if (nvalid != 1 || n100 != 1) begin failures++; $display("FAIL flush_count: got %0d/%0d expected 1/1", nvalid, n100); end
    endtask

    // cycles 22..27: flush and stall together while the hold buffer is full
    task automatic test_flush_stall;
        gnt_en = 1'b1; lat = 1;
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        flush = 1'b1; pc_target_E = 32'h200; #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL fs_req: got %b expected 0", imem_req); end
        @(negedge clk);
        stall = 1'b0; flush = 1'b0; #1;
        checks++; if (valid_D !== 1'b0 || instr_D !== NOP_W || pc_D !== 32'h100) begin failures++; $display("FAIL fs_bubble: got %b %h %h expected 0 NOP 100", valid_D, instr_D, pc_D); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL fs_target: got %b %h expected 1 200", imem_req, imem_addr); end
        @(negedge clk);
        gnt_en = 1'b0; #1;
        checks++; if (valid_D !== 1'b0) begin failures++; $display("FAIL fs_hold_cleared: got %b pc %h expected 0", valid_D, pc_D); end
        @(negedge clk); #1;
        checks++; if (valid_D !== 1'b1 || pc_D !== 32'h200 || instr_D !== 32'h200) begin failures++; $display("FAIL fs_D: got %b %h %h expected 1 200 200", valid_D, pc_D, instr_D); end
        @(negedge clk);
    endtask

    // cycles 28..34: grant withheld for four cycles
    task automatic test_gnt_low;
        logic [31:0] base;
        base = perf_bubbles;
        for (int t = 28; t <= 31; t++) begin
            #1;
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin failures++; $display("FAIL gnt_stable[%0d]: got %b %h expected 1 204", t, imem_req, imem_addr); end
            if (t > 28) begin
                checks++; if (valid_D !== 1'b0) begin failures++; $display("FAIL gnt_bubble[%0d]: got %b expected 0", t, valid_D); end
            end
            @(negedge clk);
        end
        gnt_en = 1'b1; #1;
        checks++; if (valid_D !== 1'b0) begin failures++; $display("FAIL gnt_bubble_last: got %b expected 0", valid_D); end
`ifdef IF_PERF_CNT_EN
        checks++; if (perf_bubbles - base !== 32'd4) begin failures++; $display("FAIL gnt_perf: got %0d expected 4", perf_bubbles - base); end
`else
        checks++; if (perf_bubbles !== 32'h0 || perf_fetched !== 32'h0 || base !== 32'h0) begin failures++; $display("FAIL gnt_perf_off: got %h/%h expected 0/0", perf_fetched, perf_bubbles); end
`endif
        @(negedge clk);
        lat = 3;
        @(negedge clk); #1;
        checks++; if (valid_D !== 1'b1 || pc_D !== 32'h204) begin failures++; $display("FAIL gnt_D: got %b %h expected 1 204", valid_D, pc_D); end
    endtask

    // cycles 34..38: reset while 0x208 is outstanding, response lands after release
    task automatic test_reset_mid_wait;
        rst_n = 1'b0; gnt_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; gnt_en = 1'b1; lat = 1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_D !== 1'b0) begin failures++; $display("FAIL rmw_release: got %b %h %b expected 1 0 0", imem_req, imem_addr, valid_D); end
        @(negedge clk); #1;
        checks++; if (valid_D !== 1'b0) begin failures++; $display("FAIL rmw_stale: got %b pc %h expected 0", valid_D, pc_D); end
        @(negedge clk); #1;
        checks++; if (valid_D !== 1'b1 || pc_D !== 32'h0 || instr_D !== 32'h0) begin failures++; $display("FAIL rmw_first: got %b %h %h expected 1 0 0", valid_D, pc_D, instr_D); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_stall();
        test_gnt_low();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
